// File: rtl/jtag_uart_pkg.sv
// Shared types and constants for the JTAG UART transmit-side arbitration logic.
package jtag_uart_pkg;

    localparam int unsigned DataWDefault = 8;

    typedef enum logic [0:0] {
        StIdle,
        StLock
    } arb_state_e;

endpackage

// File: rtl/jtag_uart_rr_pick.sv
// Combinational rotate-priority picker: first set request at or after i_ptr, wrapping.
module jtag_uart_rr_pick
    import jtag_uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    always_comb begin
        int unsigned w_pos;
        logic [IDX_W-1:0] w_cand;
        o_idx  = '0;
        o_any  = 1'b0;
        w_pos  = 0;
        w_cand = '0;
        // Scan farthest-first so the candidate closest to i_ptr is written last and wins.
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_pos  = (32'(i_ptr) + (NUM_REQ - 1 - k)) % NUM_REQ;
            w_cand = IDX_W'(w_pos);
            if (i_req[w_cand]) begin
                o_idx = w_cand;
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jtag_uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing the JTAG UART TX byte channel, with stall watchdog.
module jtag_uart_tx_arbiter
    import jtag_uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned DATA_W  = DataWDefault,
    parameter int unsigned TIMEOUT = 255,
    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]        i_req_last,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic                      o_tx_valid,
    output logic [DATA_W-1:0]         o_tx_data,
    input  logic                      i_tx_ready,
    output logic [IDX_W-1:0]          o_grant_idx,
    output logic                      o_busy,
    output logic                      o_timeout_pulse
);

    localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_e        r_state, w_state_nxt;
    logic [IDX_W-1:0]  r_rr, w_rr_nxt;
    logic [IDX_W-1:0]  r_grant, w_grant_nxt;
    logic [WD_W-1:0]   r_wdog, w_wdog_nxt;
    logic              r_timeout, w_timeout_nxt;

    logic [IDX_W-1:0]  w_pick_idx;
    logic              w_pick_any;
    logic              w_gvalid;
    logic [DATA_W-1:0] w_gdata;
    logic              w_xfer;
    logic              w_wd_expire;
    logic [IDX_W-1:0]  w_next_ptr;

    jtag_uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req (i_req_valid),
        .i_ptr (r_rr),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    assign w_gvalid    = i_req_valid[r_grant];
    assign w_gdata     = i_req_data[r_grant*DATA_W +: DATA_W];
    assign w_xfer      = (r_state == StLock) && w_gvalid && i_tx_ready;
    assign w_next_ptr  = (r_grant == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
    // Only a granted requester with valid low counts as stalled; backpressure never does.
    assign w_wd_expire = (TIMEOUT > 0) && (r_state == StLock) && !w_gvalid && (r_wdog == WD_LAST);

    always_comb begin
        w_state_nxt   = r_state;
        w_rr_nxt      = r_rr;
        w_grant_nxt   = r_grant;
        w_wdog_nxt    = r_wdog;
        w_timeout_nxt = 1'b0;
        o_tx_valid    = 1'b0;
        o_tx_data     = '0;
        o_req_ready   = '0;
        unique case (r_state)
            StIdle: begin
                if (w_pick_any) begin
                    w_state_nxt = StLock;
                    w_grant_nxt = w_pick_idx;
                    w_wdog_nxt  = '0;
                end
            end
            StLock: begin
                o_tx_valid           = w_gvalid;
                o_tx_data            = w_gdata;
                o_req_ready[r_grant] = i_tx_ready;
                if (w_xfer) begin
                    w_wdog_nxt = '0;
                    if (i_req_last[r_grant]) begin
                        w_state_nxt = StIdle;
                        w_rr_nxt    = w_next_ptr;
                    end
                end else if (w_wd_expire) begin
                    w_state_nxt   = StIdle;
                    w_rr_nxt      = w_next_ptr;
                    w_timeout_nxt = 1'b1;
                end else if (!w_gvalid && (TIMEOUT > 0)) begin
                    w_wdog_nxt = r_wdog + 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_rr      <= '0;
            r_grant   <= '0;
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rr      <= w_rr_nxt;
            r_grant   <= w_grant_nxt;
            r_wdog    <= w_wdog_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign o_grant_idx     = r_grant;
    assign o_busy          = (r_state == StLock);
    assign o_timeout_pulse = r_timeout;

endmodule

// File: tb/tb_jtag_uart_tx_arbiter.sv
// Directed bench: two arbiter instances (default watchdog and TIMEOUT=4) on shared stimulus.
module tb_jtag_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req_valid = 3'b000;
    logic [2:0]  req_last = 3'b000;
    logic [23:0] req_data = 24'h0;
    logic        tx_ready = 1'b0;

    logic [2:0] a_rdy, b_rdy;
    logic       a_tv, b_tv, a_busy, b_busy, a_to, b_to;
    logic [7:0] a_data, b_data;
    logic [1:0] a_g, b_g;

    int n_assert = 0;
    int n_fail = 0;
    int bad = 0;

    always #5 clk = ~clk;

    jtag_uart_tx_arbiter #(.NUM_REQ(3), .DATA_W(8), .TIMEOUT(255)) dut (
        .i_clk (clk), .i_rst_n (rst_n), .i_req_valid (req_valid), .i_req_data (req_data),
        .i_req_last (req_last), .o_req_ready (a_rdy), .o_tx_valid (a_tv), .o_tx_data (a_data),
        .i_tx_ready (tx_ready), .o_grant_idx (a_g), .o_busy (a_busy), .o_timeout_pulse (a_to)
    );

    jtag_uart_tx_arbiter #(.NUM_REQ(3), .DATA_W(8), .TIMEOUT(4)) dut_t (
        .i_clk (clk), .i_rst_n (rst_n), .i_req_valid (req_valid), .i_req_data (req_data),
        .i_req_last (req_last), .o_req_ready (b_rdy), .o_tx_valid (b_tv), .o_tx_data (b_data),
        .i_tx_ready (tx_ready), .o_grant_idx (b_g), .o_busy (b_busy), .o_timeout_pulse (b_to)
    );

    // Packed as {tx_valid, busy, timeout_pulse, req_ready[2:0], grant_idx[1:0], tx_data[7:0]}
    function automatic logic [31:0] ex(input logic tv, input logic bz, input logic to,
                                       input logic [2:0] rdy, input logic [1:0] g,
                                       input logic [7:0] d);
        return {16'h0, tv, bz, to, rdy, g, d};
    endfunction

    function logic [31:0] obs_a();
        return {16'h0, a_tv, a_busy, a_to, a_rdy, a_g, a_data};
    endfunction

    function logic [31:0] obs_b();
        return {16'h0, b_tv, b_busy, b_to, b_rdy, b_g, b_data};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ck(input string tag, input logic [31:0] exp);
        #1;
        chk(tag, obs_a(), exp);
    endtask

    task automatic ckb(input string tag, input logic [31:0] exp);
        #1;
        chk(tag, obs_b(), exp);
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
        req_valid[i]      = v;
        req_data[i*8 +: 8] = d;
        req_last[i]       = l;
    endtask

    initial begin
        // 1: reset held with all requesters valid
        tx_ready = 1'b1;
        set_req(0, 1'b1, 8'hA0, 1'b0);
        set_req(1, 1'b1, 8'hB0, 1'b0);
        set_req(2, 1'b1, 8'hC0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            ck("reset", ex(0, 0, 0, 3'b000, 0, 8'h00));
        end

        // 2: three 3-byte packets in round-robin order with one bubble each
        tick(); rst_n = 1'b1; ck("arb0", ex(0, 0, 0, 3'b000, 0, 8'h00));
        tick(); ck("a0", ex(1, 1, 0, 3'b001, 0, 8'hA0));
        tick(); set_req(0, 1, 8'hA1, 0); ck("a1", ex(1, 1, 0, 3'b001, 0, 8'hA1));
        tick(); set_req(0, 1, 8'hA2, 1); ck("a2", ex(1, 1, 0, 3'b001, 0, 8'hA2));
        tick(); set_req(0, 0, 8'h00, 0); ck("bub0", ex(0, 0, 0, 3'b000, 0, 8'h00));
        tick(); ck("b0", ex(1, 1, 0, 3'b010, 1, 8'hB0));
        tick(); set_req(1, 1, 8'hB1, 0); ck("b1", ex(1, 1, 0, 3'b010, 1, 8'hB1));
        tick(); set_req(1, 1, 8'hB2, 1); ck("b2", ex(1, 1, 0, 3'b010, 1, 8'hB2));
        tick(); set_req(1, 0, 8'h00, 0); ck("bub1", ex(0, 0, 0, 3'b000, 1, 8'h00));
        tick(); ck("c0", ex(1, 1, 0, 3'b100, 2, 8'hC0));
        tick(); set_req(2, 1, 8'hC1, 0); ck("c1", ex(1, 1, 0, 3'b100, 2, 8'hC1));
        tick(); set_req(2, 1, 8'hC2, 1); ck("c2", ex(1, 1, 0, 3'b100, 2, 8'hC2));
        tick(); set_req(2, 0, 8'h00, 0); ck("bub2", ex(0, 0, 0, 3'b000, 2, 8'h00));

        // 3: competitors arrive mid-packet; afterwards rotation goes 2 then 0
        tick(); set_req(1, 1, 8'hB0, 0); ck("t3_idle", ex(0, 0, 0, 3'b000, 2, 8'h00));
        tick(); set_req(0, 1, 8'hA5, 1); set_req(2, 1, 8'hC5, 1);
        ck("t3_b0", ex(1, 1, 0, 3'b010, 1, 8'hB0));
        tick(); set_req(1, 1, 8'hB1, 1); ck("t3_b1", ex(1, 1, 0, 3'b010, 1, 8'hB1));
        tick(); set_req(1, 0, 8'h00, 0); ck("t3_bub", ex(0, 0, 0, 3'b000, 1, 8'h00));
        tick(); ck("t3_c5", ex(1, 1, 0, 3'b100, 2, 8'hC5));
        tick(); set_req(2, 0, 8'h00, 0); ck("t3_bub2", ex(0, 0, 0, 3'b000, 2, 8'h00));
        tick(); ck("t3_a5", ex(1, 1, 0, 3'b001, 0, 8'hA5));
        tick(); set_req(0, 0, 8'h00, 0); ck("t3_done", ex(0, 0, 0, 3'b000, 0, 8'h00));

        // 4: long backpressure must not trip the watchdog
        tick(); set_req(1, 1, 8'hD0, 1); tx_ready = 1'b0;
        ck("t4_arb", ex(0, 0, 0, 3'b000, 0, 8'h00));
        for (int i = 0; i < 400; i++) begin
            tick(); #1;
            if (obs_a() !== ex(1, 1, 0, 3'b000, 1, 8'hD0)) bad++;
        end
        chk("t4_hold_cycles_bad", 32'(bad), 32'd0);
        tick(); tx_ready = 1'b1; ck("t4_accept", ex(1, 1, 0, 3'b010, 1, 8'hD0));
        tick(); set_req(1, 0, 8'h00, 0); ck("t4_done", ex(0, 0, 0, 3'b000, 1, 8'h00));

        // 5: TIMEOUT=4 instance, requester 0 stalls after one byte
        tick(); set_req(0, 1, 8'hE0, 0); ckb("t5_arb", ex(0, 0, 0, 3'b000, 1, 8'h00));
        tick(); ckb("t5_e0", ex(1, 1, 0, 3'b001, 0, 8'hE0));
        tick(); set_req(0, 0, 8'h00, 0); set_req(1, 1, 8'hF0, 1);
        ckb("t5_idle0", ex(0, 1, 0, 3'b001, 0, 8'h00));
        tick(); ckb("t5_idle1", ex(0, 1, 0, 3'b001, 0, 8'h00));
        tick(); ckb("t5_idle2", ex(0, 1, 0, 3'b001, 0, 8'h00));
        tick(); ckb("t5_idle3", ex(0, 1, 0, 3'b001, 0, 8'h00));
        tick(); ckb("t5_pulse", ex(0, 0, 1, 3'b000, 0, 8'h00));
        ck("t5_long_wdog", ex(0, 1, 0, 3'b001, 0, 8'h00));
        tick(); ckb("t5_regrant", ex(1, 1, 0, 3'b010, 1, 8'hF0));

        // 6: reset mid-packet drops the grant and restarts rotation at requester 0
        tick(); set_req(1, 0, 8'h00, 0); rst_n = 1'b0;
        tick(); rst_n = 1'b1; set_req(1, 1, 8'h90, 1);
        ckb("t6_arb", ex(0, 0, 0, 3'b000, 0, 8'h00));
        ck("t6_arb_a", ex(0, 0, 0, 3'b000, 0, 8'h00));
        tick(); ckb("t6_h0", ex(1, 1, 0, 3'b010, 1, 8'h90));
        tick(); set_req(1, 0, 8'h00, 0); set_req(2, 1, 8'h50, 0);
        ckb("t6_bub", ex(0, 0, 0, 3'b000, 1, 8'h00));
        tick(); ckb("t6_j0", ex(1, 1, 0, 3'b100, 2, 8'h50));
        tick(); set_req(2, 1, 8'h51, 0); rst_n = 1'b0;
        ckb("t6_j1", ex(1, 1, 0, 3'b100, 2, 8'h51));
        tick(); rst_n = 1'b1; set_req(0, 1, 8'hA7, 1); set_req(1, 1, 8'h92, 1);
        ckb("t6_rst", ex(0, 0, 0, 3'b000, 0, 8'h00));
        ck("t6_rst_a", ex(0, 0, 0, 3'b000, 0, 8'h00));
        tick(); ckb("t6_restart", ex(1, 1, 0, 3'b001, 0, 8'hA7));
        ck("t6_restart_a", ex(1, 1, 0, 3'b001, 0, 8'hA7));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
